// File: rtl/dispensador_billetes_if.sv
// Bus between the ATM controller / cash mechanism and the note dispenser:
// request strobe and amount, reload command, note handshake, completion
// pulses and the cassette inventory readout.
interface dispensador_billetes_if #(
  parameter int INV_W = 16
) ();
  logic              entregar_dinero;
  logic [31:0]       monto;
  logic              recargar;
  logic              billete_listo;
  logic              billete_stb;
  logic [1:0]        denominacion;
  logic              ocupado;
  logic              dispensado_ok;
  logic              error_dispensa;
  logic [INV_W-1:0]  inv_20k;
  logic [INV_W-1:0]  inv_10k;
  logic [INV_W-1:0]  inv_5k;
  logic [INV_W-1:0]  inv_1k;

  modport master (
    output entregar_dinero, monto, recargar, billete_listo,
    input  billete_stb, denominacion, ocupado, dispensado_ok, error_dispensa,
    input  inv_20k, inv_10k, inv_5k, inv_1k
  );

  modport slave (
    input  entregar_dinero, monto, recargar, billete_listo,
    output billete_stb, denominacion, ocupado, dispensado_ok, error_dispensa,
    output inv_20k, inv_10k, inv_5k, inv_1k
  );
endinterface

// File: rtl/dispensador_billetes.sv
// Note dispenser: plans a greedy 20000/10000/5000/1000 breakdown of the
// requested amount against the cassette inventory (one denomination per
// cycle), then either hands the notes out one at a time over the
// ready/strobe handshake or rejects the whole request.
module dispensador_billetes #(
  parameter int INV_W   = 16,
  parameter int INV_20K = 100,
  parameter int INV_10K = 100,
  parameter int INV_5K  = 100,
  parameter int INV_1K  = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  dispensador_billetes_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, PLAN, DISP, FIN} state_t;

  state_t            state;
  logic [31:0]       resto;
  logic [1:0]        idx;
  logic [INV_W-1:0]  n_plan [4];
  logic [INV_W-1:0]  inv    [4];
  logic              stb;
  logic [1:0]        den;
  logic              ocup;
  logic              ok;
  logic              err;

  // Face value of denomination index d (3 = largest)
  function automatic logic [31:0] valor(input logic [1:0] d);
    case (d)
      2'd3:    return 32'd20000;
      2'd2:    return 32'd10000;
      2'd1:    return 32'd5000;
      default: return 32'd1000;
    endcase
  endfunction

  // Cassette load value for denomination index d
  function automatic logic [INV_W-1:0] inv_init(input logic [1:0] d);
    case (d)
      2'd3:    return INV_W'(INV_20K);
      2'd2:    return INV_W'(INV_10K);
      2'd1:    return INV_W'(INV_5K);
      default: return INV_W'(INV_1K);
    endcase
  endfunction

  function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // Highest denomination index whose flag is set (0 if none)
  function automatic logic [1:0] mayor(input logic [3:0] q);
    logic [1:0] r;
    r = 2'd0;
    if (q[1]) r = 2'd1;
    if (q[2]) r = 2'd2;
    if (q[3]) r = 2'd3;
    return r;
  endfunction

  logic [31:0]       q_calc;
  logic [31:0]       n_calc32;
  logic [INV_W-1:0]  n_calc;
  logic [31:0]       resto_calc;
  logic [3:0]        plan_nz;
  logic [3:0]        disp_nz;

  // Planning step for the current denomination, and which denominations
  // still have notes pending after this cycle (planning / dispensing views)
  always_comb begin
    q_calc     = resto / valor(idx);
    n_calc32   = min32(q_calc, 32'(inv[idx]));
    n_calc     = INV_W'(n_calc32);
    resto_calc = resto - n_calc32 * valor(idx);
    plan_nz    = '0;
    disp_nz    = '0;
    for (int i = 0; i < 4; i++) begin
      plan_nz[i] = (2'(i) == idx) ? (n_calc != '0) : (n_plan[i] != '0);
      disp_nz[i] = (2'(i) == den) ? (n_plan[i] > INV_W'(1)) : (n_plan[i] != '0);
    end
  end

  // Control FSM: accept, plan, dispense, report; owns the inventory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      resto <= '0;
      idx   <= '0;
      stb   <= 1'b0;
      den   <= 2'd0;
      ocup  <= 1'b0;
      ok    <= 1'b0;
      err   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        n_plan[i] <= '0;
        inv[i]    <= inv_init(2'(i));
      end
    end else begin
      ok  <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          // A reload on the accepting edge is seen by the following plan
          if (bus.recargar) begin
            for (int i = 0; i < 4; i++) inv[i] <= inv_init(2'(i));
          end
          if (bus.entregar_dinero) begin
            resto <= bus.monto;
            idx   <= 2'd3;
            ocup  <= 1'b1;
            state <= PLAN;
          end
        end
        PLAN: begin
          n_plan[idx] <= n_calc;
          resto       <= resto_calc;
          idx         <= idx - 2'd1;
          if (idx == 2'd0) begin
            if (resto_calc != '0) begin
              err   <= 1'b1;
              state <= FIN;
            end else if (plan_nz == 4'b0000) begin
              ok    <= 1'b1;
              state <= FIN;
            end else begin
              stb   <= 1'b1;
              den   <= mayor(plan_nz);
              state <= DISP;
            end
          end
        end
        DISP: begin
          // The strobe is always high here, so ready alone marks a transfer
          if (bus.billete_listo) begin
            n_plan[den] <= n_plan[den] - INV_W'(1);
            inv[den]    <= inv[den] - INV_W'(1);
            if (disp_nz == 4'b0000) begin
              stb   <= 1'b0;
              ok    <= 1'b1;
              state <= FIN;
            end else begin
              den <= mayor(disp_nz);
            end
          end
        end
        FIN: begin
          ocup  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.billete_stb    = stb;
  assign bus.denominacion   = den;
  assign bus.ocupado        = ocup;
  assign bus.dispensado_ok  = ok;
  assign bus.error_dispensa = err;
  assign bus.inv_20k        = inv[3];
  assign bus.inv_10k        = inv[2];
  assign bus.inv_5k         = inv[1];
  assign bus.inv_1k         = inv[0];

endmodule

// File: tb/tb_dispensador_billetes.sv
// Bench for dispensador_billetes: three instances (default inventory,
// single 20000 note, single note of every kind) share clock, reset and the
// handshake inputs; a select picks which one receives requests and is observed.
module tb_dispensador_billetes;

  localparam int INV_W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        entregar = 1'b0;
  logic [31:0] monto = '0;
  logic        recargar = 1'b0;
  logic        listo = 1'b1;
  logic [1:0]  sel = 2'd0;

  always #5 clk = ~clk;

  dispensador_billetes_if #(.INV_W(INV_W)) if0 ();
  dispensador_billetes_if #(.INV_W(INV_W)) if1 ();
  dispensador_billetes_if #(.INV_W(INV_W)) if2 ();

  dispensador_billetes #(.INV_W(INV_W)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  dispensador_billetes #(.INV_W(INV_W), .INV_20K(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  dispensador_billetes #(.INV_W(INV_W), .INV_20K(1), .INV_10K(1), .INV_5K(1), .INV_1K(1))
    dut2 (.clk(clk), .reset(reset), .bus(if2));

  assign if0.entregar_dinero = entregar && (sel == 2'd0);
  assign if1.entregar_dinero = entregar && (sel == 2'd1);
  assign if2.entregar_dinero = entregar && (sel == 2'd2);
  assign if0.recargar = recargar && (sel == 2'd0);
  assign if1.recargar = recargar && (sel == 2'd1);
  assign if2.recargar = recargar && (sel == 2'd2);
  assign if0.monto = monto;
  assign if1.monto = monto;
  assign if2.monto = monto;
  assign if0.billete_listo = listo;
  assign if1.billete_listo = listo;
  assign if2.billete_listo = listo;

  logic [5:0]       ctl  [3];
  logic [INV_W-1:0] invs [3][4];
  assign ctl[0] = {if0.billete_stb, if0.denominacion, if0.ocupado, if0.dispensado_ok, if0.error_dispensa};
  assign ctl[1] = {if1.billete_stb, if1.denominacion, if1.ocupado, if1.dispensado_ok, if1.error_dispensa};
  assign ctl[2] = {if2.billete_stb, if2.denominacion, if2.ocupado, if2.dispensado_ok, if2.error_dispensa};
  assign invs[0][3] = if0.inv_20k; assign invs[0][2] = if0.inv_10k;
  assign invs[0][1] = if0.inv_5k;  assign invs[0][0] = if0.inv_1k;
  assign invs[1][3] = if1.inv_20k; assign invs[1][2] = if1.inv_10k;
  assign invs[1][1] = if1.inv_5k;  assign invs[1][0] = if1.inv_1k;
  assign invs[2][3] = if2.inv_20k; assign invs[2][2] = if2.inv_10k;
  assign invs[2][1] = if2.inv_5k;  assign invs[2][0] = if2.inv_1k;

  logic       m_stb, m_ocup, m_ok, m_err;
  logic [1:0] m_den;
  assign {m_stb, m_den, m_ocup, m_ok, m_err} = ctl[sel];

  int checks = 0;
  int errors = 0;
  int exp_den[$];
  int exp_out[$];

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  // Scoreboard side: every transfer and every completion pulse is popped
  always @(negedge clk) begin
    int e;
    if (m_stb === 1'b1 && listo === 1'b1) begin
      checks++;
      if (exp_den.size() == 0) begin
        errors++;
        $display("FAIL note_unexpected got den=%0d required none", m_den);
      end else begin
        e = exp_den.pop_front();
        if (int'(m_den) != e) begin
          errors++;
          $display("FAIL note_den got %0d required %0d", m_den, e);
        end
      end
    end
    if (m_ok === 1'b1 || m_err === 1'b1) begin
      checks++;
      if (exp_out.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected got ok=%0b err=%0b required none", m_ok, m_err);
      end else begin
        e = exp_out.pop_front();
        if ({m_ok, m_err} !== ((e != 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL outcome got ok=%0b err=%0b required ok=%0d", m_ok, m_err, e);
        end
      end
    end
  end

  task automatic wait_stb(output int cnt);
    cnt = 0;
    for (int c = 1; c <= 60 && cnt == 0; c++) begin
      @(negedge clk);
      if (m_stb === 1'b1) cnt = c;
    end
    if (cnt == 0) begin
      checks++; errors++;
      $display("FAIL stb_timeout got none required strobe");
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    for (int c = 1; c <= 60 && cnt == 0; c++) begin
      @(negedge clk);
      if (m_ok === 1'b1 || m_err === 1'b1) cnt = c;
    end
    if (cnt == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout got none required pulse");
    end
  endtask

  // Called just after a rising edge; rmode 1 = reload on the accepting
  // edge, 2 = reload pulse one cycle before the request
  task automatic request(input logic [31:0] m, input int rmode);
    if (rmode == 2) begin
      recargar = 1'b1;
      @(posedge clk); #1;
      recargar = 1'b0;
    end
    entregar = 1'b1;
    monto    = m;
    recargar = (rmode == 1);
    @(posedge clk); #1;
    entregar = 1'b0;
    recargar = 1'b0;
  endtask

  task automatic push_notes(input int n3, input int n2, input int n1, input int n0);
    repeat (n3) exp_den.push_back(3);
    repeat (n2) exp_den.push_back(2);
    repeat (n1) exp_den.push_back(1);
    repeat (n0) exp_den.push_back(0);
  endtask

  task automatic check_inv(input int i3, input int i2, input int i1, input int i0);
    check("inv_20k", int'(invs[sel][3]), i3);
    check("inv_10k", int'(invs[sel][2]), i2);
    check("inv_5k",  int'(invs[sel][1]), i1);
    check("inv_1k",  int'(invs[sel][0]), i0);
  endtask

  typedef struct {
    int sel;
    int monto;
    int n3, n2, n1, n0;
    int ok;
    int i3, i2, i1, i0;
    int rmode;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int c;
    int total;

    vecs[0]  = '{0, 38000, 1, 1, 1, 3, 1,  99,  99,  99,  97, 0};
    vecs[1]  = '{0,  1500, 0, 0, 0, 0, 0,  99,  99,  99,  97, 0};
    vecs[2]  = '{0,     0, 0, 0, 0, 0, 1,  99,  99,  99,  97, 0};
    vecs[3]  = '{0, 25000, 1, 0, 1, 0, 1,  99, 100,  99, 100, 1};
    vecs[4]  = '{0,  7000, 0, 0, 1, 2, 1,  99, 100,  98,  98, 0};
    vecs[5]  = '{1, 60000, 1, 4, 0, 0, 1,   0,  96, 100, 100, 0};
    vecs[6]  = '{1, 20000, 0, 2, 0, 0, 1,   0,  94, 100, 100, 0};
    vecs[7]  = '{2, 40000, 0, 0, 0, 0, 0,   1,   1,   1,   1, 0};
    vecs[8]  = '{2, 36000, 1, 1, 1, 1, 1,   0,   0,   0,   0, 0};
    vecs[9]  = '{2,  1000, 0, 0, 0, 0, 0,   0,   0,   0,   0, 0};
    vecs[10] = '{2,  1000, 0, 0, 0, 1, 1,   1,   1,   1,   0, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    sel = 2'd0;
    check("rst_stb", int'(m_stb), 0);
    check("rst_ocup", int'(m_ocup), 0);
    check("rst_den", int'(m_den), 0);
    check_inv(100, 100, 100, 100);
    sel = 2'd1; #1;
    check("rst_inv20k_dut1", int'(invs[1][3]), 1);
    sel = 2'd2; #1;
    check("rst_inv1k_dut2", int'(invs[2][0]), 1);
    sel = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Table of single requests with the mechanism always ready
    for (int i = 0; i < 11; i++) begin
      sel = 2'(vecs[i].sel);
      #1;
      push_notes(vecs[i].n3, vecs[i].n2, vecs[i].n1, vecs[i].n0);
      exp_out.push_back(vecs[i].ok);
      total = vecs[i].n3 + vecs[i].n2 + vecs[i].n1 + vecs[i].n0;
      request(vecs[i].monto, vecs[i].rmode);
      check("ocup_accept", int'(m_ocup), 1);
      if (total > 0) begin
        wait_stb(c);
        check("lat_first_stb", c, 5);
        wait_done(c);
        check("lat_done_disp", c, total);
      end else begin
        wait_done(c);
        check("lat_done_plan", c, 5);
      end
      @(posedge clk); #1;
      check("ocup_end", int'(m_ocup), 0);
      check("notes_left", exp_den.size(), 0);
      check_inv(vecs[i].i3, vecs[i].i2, vecs[i].i1, vecs[i].i0);
    end

    // Backpressure on the second note (inventory 99,100,98,98)
    sel = 2'd0;
    #1;
    push_notes(1, 0, 1, 0);
    exp_out.push_back(1);
    request(25000, 0);
    wait_stb(c);
    @(posedge clk); #1;
    listo = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_stb", int'(m_stb), 1);
      check("bp_den", int'(m_den), 1);
      check("bp_inv5k", int'(invs[0][1]), 98);
    end
    @(posedge clk); #1;
    listo = 1'b1;
    wait_done(c);
    @(posedge clk); #1;
    check("bp_ocup", int'(m_ocup), 0);
    check_inv(98, 100, 97, 98);

    // Request during DISP is dropped
    push_notes(0, 0, 1, 2);
    exp_out.push_back(1);
    request(7000, 0);
    wait_stb(c);
    @(posedge clk); #1;
    entregar = 1'b1;
    monto    = 20000;
    @(posedge clk); #1;
    entregar = 1'b0;
    wait_done(c);
    repeat (6) @(posedge clk);
    #1;
    check("busy_ocup", int'(m_ocup), 0);
    check("busy_notes_left", exp_den.size(), 0);
    check_inv(98, 100, 96, 96);

    // Reload from IDLE
    recargar = 1'b1;
    @(posedge clk); #1;
    recargar = 1'b0;
    check_inv(100, 100, 100, 100);

    // Reset after the second of four notes
    push_notes(0, 0, 0, 4);
    exp_out.push_back(1);
    request(4000, 0);
    wait_stb(c);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_inv1k", int'(invs[0][0]), 98);
    check("pre_rst_stb", int'(m_stb), 1);
    reset = 1'b1;
    #1;
    check("arst_stb", int'(m_stb), 0);
    check("arst_ocup", int'(m_ocup), 0);
    check("arst_den", int'(m_den), 0);
    check("arst_ok", int'(m_ok), 0);
    check("arst_err", int'(m_err), 0);
    check_inv(100, 100, 100, 100);
    exp_den.delete();
    exp_out.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_ocup", int'(m_ocup), 0);
    check("post_rst_stb", int'(m_stb), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
